// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI bus arbiter: FSM state encoding and index/one-hot conversion.
package spi_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StSetup,
    StLoad,
    StWait,
    StHold,
    StGap
  } arb_state_e;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, wrapping.
module spi_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after ptr is written last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one byte-level SPI master engine between N_REQ requesters with round-robin
// arbitration per transaction, owning the per-requester chip selects.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ*8-1:0] tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   tx_pop,
  output logic [7:0]         rx_data,
  output logic [N_REQ-1:0]   rx_valid,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   cs_n,
  output logic               eng_start,
  output logic [7:0]         eng_data,
  input  logic               eng_done,
  input  logic [7:0]         eng_rx
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned MAX_CNT = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] ptr_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] win_oh;
  logic [7:0]       tx_arr  [N_REQ];
  logic [LEN_W-1:0] len_arr [N_REQ];

  spi_rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req(req),
    .ptr(ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      tx_arr[i]  = tx_data[i*8 +: 8];
      len_arr[i] = req_len[i*LEN_W +: LEN_W];
    end
  end

  assign pick_oh = N_REQ'(idx_to_onehot(3'(pick_idx)));
  assign win_oh  = N_REQ'(idx_to_onehot(3'(win_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      win_q     <= '0;
      ptr_q     <= IDX_W'(N_REQ - 1);
      rem_q     <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      tx_pop    <= '0;
      rx_data   <= '0;
      rx_valid  <= '0;
      done      <= '0;
      cs_n      <= '1;
      eng_start <= 1'b0;
      eng_data  <= '0;
    end else begin
      tx_pop    <= '0;
      rx_valid  <= '0;
      done      <= '0;
      eng_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) state_q <= StArb;
        end
        StArb: begin
          if (!pick_any) begin
            state_q <= StIdle;
          end else begin
            win_q <= pick_idx;
            ptr_q <= pick_idx;
            rem_q <= len_arr[pick_idx];
            grant <= pick_oh;
            cnt_q <= '0;
            // Zero-length requests complete without touching the chip select.
            if (len_arr[pick_idx] == '0) begin
              done    <= pick_oh;
              state_q <= StGap;
            end else begin
              cs_n    <= ~pick_oh;
              state_q <= StSetup;
            end
          end
        end
        StSetup: begin
          if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
            eng_start <= 1'b1;
            eng_data  <= tx_arr[win_q];
            tx_pop    <= win_oh;
            state_q   <= StLoad;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StLoad: begin
          state_q <= StWait;
        end
        StWait: begin
          if (eng_done) begin
            rx_data  <= eng_rx;
            rx_valid <= win_oh;
            rem_q    <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= StHold;
            end else begin
              eng_start <= 1'b1;
              eng_data  <= tx_arr[win_q];
              tx_pop    <= win_oh;
              state_q   <= StLoad;
            end
          end
        end
        StHold: begin
          cs_n    <= '1;
          done    <= win_oh;
          grant   <= '0;
          cnt_q   <= '0;
          state_q <= StGap;
        end
        StGap: begin
          grant <= '0;
          if (cnt_q == CNT_W'(CS_GAP - 1)) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a fixed-latency engine model and requester byte sources.
module tb_spi_bus_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned LW  = 4;
  localparam int unsigned CSS = 2;
  localparam int unsigned CSG = 2;

  localparam int WDone    = 0;
  localparam int WRx      = 1;
  localparam int WStart   = 2;
  localparam int WGrant   = 3;
  localparam int WAnyDone = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N*8-1:0] tx_data = '0;
  logic [N-1:0]  grant, tx_pop, rx_valid, done, cs_n;
  logic [7:0]    rx_data, eng_data;
  logic          eng_start;
  logic          eng_done = 1'b0;
  logic [7:0]    eng_rx = '0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .N_REQ(N),
    .LEN_W(LW),
    .CS_SETUP(CSS),
    .CS_GAP(CSG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_len(req_len),
    .tx_data(tx_data),
    .grant(grant),
    .tx_pop(tx_pop),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .done(done),
    .cs_n(cs_n),
    .eng_start(eng_start),
    .eng_data(eng_data),
    .eng_done(eng_done),
    .eng_rx(eng_rx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tx_byte(input int i, input int k);
    if (i == 0 && k == 0) return 8'hA5;
    if (i == 0 && k == 1) return 8'h3C;
    return 8'(i * 16 + k);
  endfunction

  function automatic logic [7:0] rx_byte(input int n);
    if (n == 0) return 8'h11;
    if (n == 1) return 8'h22;
    return 8'(n * 7 + 3);
  endfunction

  // Requesters: advance to the next byte on each tx_pop.
  int pop_cnt[N];
  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (tx_pop[i]) pop_cnt[i]++;
      tx_data[i*8 +: 8] = tx_byte(i, pop_cnt[i]);
    end
  end

  // Engine: answers each eng_start three cycles later.
  int pend  = 0;
  int eng_n = 0;
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        eng_done = 1'b1;
        eng_rx   = rx_byte(eng_n);
        eng_n++;
      end
    end
    if (eng_start) pend = 3;
  end

  int done_cnt[N];
  int rx_cnt = 0, start_cnt = 0, low_cnt = 0, overlap = 0, bad = 0;
  int high_run = 0, min_gap = 1000;
  bit seen_low = 1'b0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] grant_log[$];
  logic [7:0]   sent[$];
  logic [7:0]   rx_log[$];

  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) if (done[i]) done_cnt[i]++;
    if (|rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
      if (rx_valid !== grant) bad++;
    end
    if (eng_start) begin
      start_cnt++;
      sent.push_back(eng_data);
      if (tx_pop !== grant || ~cs_n !== grant) bad++;
    end else if (tx_pop !== '0) begin
      bad++;
    end
    if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
    prev_grant = grant;
    if ($countones(~cs_n) > 1) overlap++;
    if (cs_n != '1) begin
      low_cnt++;
      if (seen_low && high_run > 0 && high_run < min_gap) min_gap = high_run;
      seen_low = 1'b1;
      high_run = 0;
    end else begin
      high_run++;
    end
  end

  task automatic set_len(input int i, input logic [LW-1:0] v);
    req_len[i*LW +: LW] = v;
  endtask

  task automatic wait_for(input string tag, input int sel, input int idx, input int budget);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < budget && !hit; c++) begin
      @(negedge clk);
      case (sel)
        WDone:   hit = done[idx];
        WRx:     hit = rx_valid[idx];
        WStart:  hit = eng_start;
        WGrant:  hit = |grant;
        default: hit = |done;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  int b_start, b_low, b_done, b_rx, b_sent, b_pop, b_eng, g0;
  logic [N-1:0] exp_g[4];

  initial begin
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_tx_pop", tx_pop, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_data", eng_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single two-byte request from requester 0.
    set_len(0, 2);
    req = 4'b0001;
    @(negedge clk);
    check("t1_arb_cs", cs_n, 4'hF);
    @(negedge clk);
    check("t1_cs_fall", cs_n, 4'hE);
    check("t1_grant", grant, 4'h1);
    check("t1_setup0_start", eng_start, 0);
    @(negedge clk);
    check("t1_setup1_start", eng_start, 0);
    @(negedge clk);
    check("t1_start0", eng_start, 1);
    check("t1_data0", eng_data, 8'hA5);
    check("t1_pop0", tx_pop, 4'h1);
    repeat (4) @(negedge clk);
    check("t1_rxv0", rx_valid, 4'h1);
    check("t1_rx0", rx_data, 8'h11);
    check("t1_start1", eng_start, 1);
    check("t1_data1", eng_data, 8'h3C);
    repeat (4) @(negedge clk);
    check("t1_rxv1", rx_valid, 4'h1);
    check("t1_rx1", rx_data, 8'h22);
    check("t1_hold_cs", cs_n, 4'hE);
    check("t1_hold_done", done, 0);
    @(negedge clk);
    check("t1_done", done, 4'h1);
    check("t1_done_cs", cs_n, 4'hF);
    check("t1_done_grant", grant, 0);
    req = '0;
    @(negedge clk);
    check("t1_gap_cs", cs_n, 4'hF);
    check("t1_gap_done", done, 0);
    @(negedge clk);
    check("t1_idle_cs", cs_n, 4'hF);
    repeat (3) @(negedge clk);

    // Contention between requesters 1 and 3.
    g0 = grant_log.size();
    set_len(1, 1);
    set_len(3, 1);
    req = 4'b1010;
    for (int t = 0; t < 4; t++) wait_for("t2_done", WAnyDone, 0, 60);
    req = '0;
    repeat (4) @(negedge clk);
    check("t2_grants", grant_log.size() - g0, 4);
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010; exp_g[3] = 4'b1000;
    if (grant_log.size() >= g0 + 4)
      for (int t = 0; t < 4; t++) check("t2_order", grant_log[g0+t], exp_g[t]);

    // Zero-length request.
    b_start = start_cnt; b_low = low_cnt; b_done = done_cnt[2];
    set_len(2, 0);
    req = 4'b0100;
    wait_for("t3_done_seen", WDone, 2, 20);
    req = '0;
    repeat (4) @(negedge clk);
    check("t3_done_cnt", done_cnt[2] - b_done, 1);
    check("t3_no_start", start_cnt - b_start, 0);
    check("t3_no_cs", low_cnt - b_low, 0);

    // Pointer wraps from 3 back to 0.
    set_len(3, 1);
    req = 4'b1000;
    wait_for("t4_done3", WDone, 3, 60);
    set_len(0, 1);
    req = 4'b1001;
    wait_for("t4_grant_seen", WGrant, 0, 20);
    check("t4_wrap_grant", grant, 4'b0001);
    wait_for("t4_done0", WDone, 0, 60);
    req = '0;
    repeat (4) @(negedge clk);

    // Reset while waiting on the engine.
    set_len(0, 3);
    req = 4'b0001;
    wait_for("t5_start", WStart, 0, 30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_cs", cs_n, 4'hF);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_start", eng_start, 0);
    req = '0;
    b_start = start_cnt; b_done = done_cnt[0]; b_rx = rx_cnt; b_eng = eng_n;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_late_done_seen", eng_n - b_eng, 1);
    check("t5_no_done", done_cnt[0] - b_done, 0);
    check("t5_no_rx", rx_cnt - b_rx, 0);
    check("t5_no_start", start_cnt - b_start, 0);
    check("t5_idle_cs", cs_n, 4'hF);
    set_len(0, 1);
    set_len(1, 1);
    req = 4'b0011;
    wait_for("t5_grant_seen", WGrant, 0, 20);
    check("t5_ptr_reset", grant, 4'b0001);
    wait_for("t5_done0", WDone, 0, 60);
    req = '0;
    repeat (4) @(negedge clk);

    // Request dropped after the first byte of a four-byte transfer.
    b_start = start_cnt; b_done = done_cnt[1]; b_sent = sent.size();
    b_pop = pop_cnt[1]; b_rx = rx_log.size(); b_eng = eng_n;
    set_len(1, 4);
    req = 4'b0010;
    wait_for("t6_rx_first", WRx, 1, 60);
    req = '0;
    wait_for("t6_done_seen", WDone, 1, 100);
    repeat (4) @(negedge clk);
    check("t6_starts", start_cnt - b_start, 4);
    check("t6_done_cnt", done_cnt[1] - b_done, 1);
    for (int j = 0; j < 4; j++) begin
      if (sent.size() > b_sent + j) check("t6_tx", sent[b_sent+j], tx_byte(1, b_pop + j));
      if (rx_log.size() > b_rx + j) check("t6_rx", rx_log[b_rx+j], rx_byte(b_eng + j));
    end

    check("cs_overlap", overlap, 0);
    check("start_pop_cs_consistency", bad, 0);
    check("min_cs_gap", min_gap, CSG + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
